mbist_march_ctrl: RTL and testbench

- Upstream MBIST engine for the 64x8 single-port SRAM.
- Runs a March C- sequence by driving the SRAM's ramaddr/ramin/rwbar/cs.
- Compares the SRAM's ramout against the expected data and reports pass/fail, plus diagnostics for the first failure.
- Sits between the test-access start request and the SRAM instance.

---
 rtl/mbist_march_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller for a 64x8 single-port SRAM with first-failure capture.
// Define MBIST_STOP_ON_FAIL_EN to end the test at the first mismatch.
module mbist_march_ctrl #(
  parameter int                ADDR_W = 6,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] BG     = '0,
  parameter int                ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramin,
  output logic              rwbar,
  output logic              cs,
  input  logic [DATA_W-1:0] ramout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [2:0]        fail_elem,
  output logic [ERR_W-1:0]  err_count
);

`ifdef MBIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_OP   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0]        E_LAST = 3'd5;
  localparam logic [ADDR_W-1:0] A_MAX  = {ADDR_W{1'b1}};

  logic [1:0] state, n_state;
  logic [2:0] elem, n_elem;
  logic       op, n_op;     // 0 = first op of element, 1 = second (E1..E4 only)
  logic       cap, n_cap;   // read CAPTURE sub-phase
  logic [ADDR_W-1:0] n_addr;

  logic is_desc, two_op, is_wr, last_op, last_addr, mismatch, n_wr;
  logic [DATA_W-1:0] rd_exp;

  function automatic logic elem_desc(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic elem_two_op(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  function automatic logic elem_wr(input logic [2:0] e, input logic o);
    return (e == 3'd0) || (elem_two_op(e) && o);
  endfunction

  // E1/E3 write the "1" background, E0/E2/E4 write "0"
  function automatic logic [DATA_W-1:0] wr_pat(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? ~BG : BG;
  endfunction

  always_comb begin
    is_desc   = elem_desc(elem);
    two_op    = elem_two_op(elem);
    is_wr     = elem_wr(elem, op);
    last_op   = two_op ? op : 1'b1;
    last_addr = is_desc ? (ramaddr == '0) : (ramaddr == A_MAX);
    rd_exp    = ((elem == 3'd2) || (elem == 3'd4)) ? ~BG : BG;
    mismatch  = (state == S_OP) && cap && (ramout != rd_exp);
  end

  always_comb begin
    n_state = state;
    n_elem  = elem;
    n_addr  = ramaddr;
    n_op    = op;
    n_cap   = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) n_state = S_LOAD;
      S_LOAD: begin
        n_state = S_OP;
        n_elem  = '0;
        n_addr  = '0;
        n_op    = 1'b0;
      end
      S_OP: begin
        if (!is_wr && !cap) begin
          n_cap = 1'b1;
        end else if (!last_op) begin
          n_op = 1'b1;
        end else begin
          n_op = 1'b0;
          if (!last_addr) begin
            n_addr = is_desc ? ramaddr - 1'b1 : ramaddr + 1'b1;
          end else if (elem == E_LAST) begin
            n_state = S_DONE;
          end else begin
            n_elem = elem + 3'd1;
            n_addr = elem_desc(elem + 3'd1) ? A_MAX : '0;
          end
        end
        if (STOP_ON_FAIL && mismatch) n_state = S_DONE;
      end
      default: n_state = S_IDLE;
    endcase
    n_wr = (n_state == S_OP) && elem_wr(n_elem, n_op);
  end

  // SRAM strobes are registered from the next-cycle operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      elem      <= '0;
      op        <= 1'b0;
      cap       <= 1'b0;
      ramaddr   <= '0;
      ramin     <= '0;
      rwbar     <= 1'b1;
      cs        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_elem <= '0;
      err_count <= '0;
    end else begin
      state   <= n_state;
      elem    <= n_elem;
      op      <= n_op;
      cap     <= n_cap;
      ramaddr <= n_addr;
      cs      <= (n_state == S_OP);
      rwbar   <= !n_wr;
      ramin   <= n_wr ? wr_pat(n_elem) : '0;
      busy    <= (n_state == S_LOAD) || (n_state == S_OP);
      done    <= (n_state == S_DONE);
      if (n_state == S_LOAD) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
        fail_elem <= '0;
        err_count <= '0;
      end else if (mismatch) begin
        if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= ramaddr;
          fail_data <= ramout;
          fail_elem <= elem;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: behavioural SRAM with a read-path stuck-at fault,
// table-driven fault cases, random faults against a March C- reference model.
module tb_mbist_march_ctrl;

`ifdef MBIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [5:0] ramaddr, fail_addr;
  logic [7:0] ramin, ramout, fail_data, err_count;
  logic       rwbar, cs, busy, done, fail;
  logic [2:0] fail_elem;

  always #5 clk = ~clk;

  mbist_march_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .ramaddr(ramaddr), .ramin(ramin),
    .rwbar(rwbar), .cs(cs), .ramout(ramout), .busy(busy), .done(done),
    .fail(fail), .fail_addr(fail_addr), .fail_data(fail_data),
    .fail_elem(fail_elem), .err_count(err_count)
  );

  // SRAM model: registered address, read data valid the cycle after a read edge
  logic [7:0] mem [64];
  logic [5:0] rd_addr;
  logic       rd_vld;
  int         fa = -1;
  logic [7:0] m1 = 8'h00, m0 = 8'h00;

  always @(posedge clk) begin
    if (cs && !rwbar) mem[ramaddr] <= ramin;
    rd_vld <= cs && rwbar;
    if (cs && rwbar) rd_addr <= ramaddr;
  end

  always_comb begin
    ramout = 8'h00;
    if (rd_vld) begin
      ramout = mem[rd_addr];
      if (int'(rd_addr) == fa) ramout = (ramout | m1) & ~m0;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: walk March C- over an array memory, one trace entry per SRAM cycle
  typedef struct {
    int ops; int err; int fail; int faddr; int felem; int fdata;
  } res_t;

  int m_addr [1024];
  int m_rw   [1024];
  int m_din  [1024];
  int t_addr [1024];
  int t_rw   [1024];
  int t_din  [1024];

  task automatic model(input int f, input logic [7:0] s1, input logic [7:0] s0, output res_t r);
    logic [7:0] mm [64];
    logic [7:0] expv, obs, wv;
    int a, cyc;
    r = '{default: 0};
    cyc = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 64; i++) begin
        a = (e == 3 || e == 4) ? 63 - i : i;
        if (e > 0) begin
          expv = (e == 2 || e == 4) ? 8'hFF : 8'h00;
          obs  = mm[a];
          if (a == f) obs = (obs | s1) & ~s0;
          for (int k = 0; k < 2; k++) begin
            m_addr[cyc] = a; m_rw[cyc] = 1; m_din[cyc] = 0; cyc++;
          end
          if (obs != expv) begin
            if (r.fail == 0) begin
              r.fail = 1; r.faddr = a; r.felem = e; r.fdata = int'(obs);
            end
            if (r.err < 255) r.err++;
            if (STOP) begin
              r.ops = cyc;
              return;
            end
          end
        end
        if (e < 5) begin
          wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
          mm[a] = wv;
          m_addr[cyc] = a; m_rw[cyc] = 0; m_din[cyc] = int'(wv); cyc++;
        end
      end
    end
    r.ops = cyc;
  endtask

  // One full test: start pulse, optional start re-pulse mid-run, trace capture
  task automatic do_run(input int pulse_at, output int busy_cyc, output int ops);
    int n;
    bit pulsed;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("load_busy", int'(busy), 1);
    chk("load_clears", int'({done, fail, cs}) + int'(err_count), 0);
    busy_cyc = 0; ops = 0; n = 0; pulsed = 0;
    while (!done && n < 3000) begin
      if (busy) busy_cyc++;
      if (cs && ops < 1024) begin
        t_addr[ops] = int'(ramaddr); t_rw[ops] = int'(rwbar); t_din[ops] = int'(ramin);
      end
      if (cs) ops++;
      if (!pulsed && pulse_at >= 0 && ops >= pulse_at) begin
        start = 1'b1; pulsed = 1;
      end else begin
        start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    if (n >= 3000) chk("run_timeout", n, 0);
  endtask

  task automatic check_run(input string tag, input res_t r, input int busy_cyc, input int ops);
    int bad, cs_hi;
    chk({tag, "_ops"}, ops, r.ops);
    chk({tag, "_busy_cycles"}, busy_cyc, r.ops + 1);
    chk({tag, "_done"}, int'({done, busy}), 2);
    chk({tag, "_fail"}, int'(fail), r.fail);
    chk({tag, "_err_count"}, int'(err_count), r.err);
    if (r.fail != 0) begin
      chk({tag, "_fail_addr"}, int'(fail_addr), r.faddr);
      chk({tag, "_fail_elem"}, int'(fail_elem), r.felem);
      chk({tag, "_fail_data"}, int'(fail_data), r.fdata);
    end
    bad = 0;
    for (int i = 0; i < ops && i < r.ops && i < 1024; i++)
      if (t_addr[i] != m_addr[i] || t_rw[i] != m_rw[i] || t_din[i] != m_din[i]) bad++;
    chk({tag, "_trace_mismatches"}, bad, 0);
    cs_hi = 0;
    for (int i = 0; i < 3; i++) begin
      if (cs) cs_hi++;
      @(negedge clk);
    end
    chk({tag, "_cs_idle_after_done"}, cs_hi, 0);
  endtask

  typedef struct {
    int fa; logic [7:0] m1; logic [7:0] m0;
    int fail; int faddr; int felem; int fdata; int err;
  } vec_t;

  vec_t vt [4];
  res_t r;
  int   bc, oc, n;

  initial begin
    vt[0] = '{fa: -1, m1: 8'h00, m0: 8'h00, fail: 0, faddr: 0,  felem: 0, fdata: 0,     err: 0};
    vt[1] = '{fa: 5,  m1: 8'h08, m0: 8'h00, fail: 1, faddr: 5,  felem: 1, fdata: 8'h08, err: 3};
    vt[2] = '{fa: 63, m1: 8'h00, m0: 8'h01, fail: 1, faddr: 63, felem: 2, fdata: 8'hFE, err: 2};
    vt[3] = '{fa: 0,  m1: 8'h80, m0: 8'h00, fail: 1, faddr: 0,  felem: 1, fdata: 8'h80, err: 3};

    #12;
    chk("reset_cs", int'(cs), 0);
    chk("reset_rwbar", int'(rwbar), 1);
    chk("reset_others", int'(ramaddr) + int'(ramin) + int'({busy, done, fail}) +
        int'(fail_addr) + int'(fail_data) + int'(fail_elem) + int'(err_count), 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start", int'({busy, cs, done}), 0);

    for (int v = 0; v < 4; v++) begin
      fa = vt[v].fa; m1 = vt[v].m1; m0 = vt[v].m0;
      model(fa, m1, m0, r);
      do_run(-1, bc, oc);
      chk($sformatf("vec%0d_fail", v), int'(fail), vt[v].fail);
      chk($sformatf("vec%0d_err", v), int'(err_count), (STOP && vt[v].err > 0) ? 1 : vt[v].err);
      if (vt[v].fail != 0) begin
        chk($sformatf("vec%0d_faddr", v), int'(fail_addr), vt[v].faddr);
        chk($sformatf("vec%0d_felem", v), int'(fail_elem), vt[v].felem);
        chk($sformatf("vec%0d_fdata", v), int'(fail_data), vt[v].fdata);
      end
      if (vt[v].fail == 0 || !STOP) chk($sformatf("vec%0d_busy961", v), bc, 961);
      if (v == 1 && STOP) chk("stop_ops_to_idx80", oc, 81);
      if (v == 0) begin
        chk("e3_first_issue", t_addr[448] * 4 + t_rw[448] * 2 + (t_din[448] == 0 ? 1 : 0), 63 * 4 + 3);
        chk("e3_first_capture", t_addr[449] * 2 + t_rw[449], 63 * 2 + 1);
        chk("e3_first_write", t_addr[450] * 512 + t_rw[450] * 256 + t_din[450], 63 * 512 + 255);
        chk("e5_last_read_addr", t_addr[959] * 2 + t_rw[959], 63 * 2 + 1);
      end
      check_run($sformatf("vec%0d", v), r, bc, oc);
    end

    // start re-pulsed while busy has no effect on run length
    fa = -1; m1 = 8'h00; m0 = 8'h00;
    model(fa, m1, m0, r);
    do_run(100, bc, oc);
    chk("busy_start_ignored_ops", oc, 960);
    check_run("busy_start", r, bc, oc);

    // reset mid-run at operation cycle 300
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    oc = 0; n = 0;
    while (oc < 300 && n < 2000) begin
      if (cs) oc++;
      n++;
      @(negedge clk);
    end
    chk("reach_op300", oc, 300);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_strobes", int'({cs, ~rwbar}) + int'(ramaddr) + int'(ramin), 0);
    chk("async_rst_status", int'({busy, done, fail}) + int'(err_count) + int'(fail_addr) +
        int'(fail_data) + int'(fail_elem), 0);
    @(negedge clk) rst = 1'b0;
    do_run(-1, bc, oc);
    check_run("after_rst", r, bc, oc);

    // random single stuck-at faults against the reference model
    for (int k = 0; k < 4; k++) begin
      int kind, b;
      fa = $urandom_range(0, 63);
      b = $urandom_range(0, 7);
      kind = $urandom_range(0, 2);
      m1 = (kind == 1) ? (8'h01 << b) : 8'h00;
      m0 = (kind == 2) ? (8'h01 << b) : 8'h00;
      model(fa, m1, m0, r);
      do_run(-1, bc, oc);
      check_run($sformatf("rand%0d", k), r, bc, oc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
